// File: rtl/chime_alarm_ctrl_pkg.sv
// Shared definitions for the chime/alarm buzzer sequencer: state and buzzer
// codes, chime second constants and BCD helpers.
package chime_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2
    } state_e;

    localparam logic [1:0] BUZZ_OFF   = 2'b00;
    localparam logic [1:0] BUZZ_SHORT = 2'b01;
    localparam logic [1:0] BUZZ_LONG  = 2'b10;
    localparam logic [1:0] BUZZ_ALARM = 2'b11;

    localparam logic [6:0] CHIME_MIN   = 7'd59;
    localparam logic [6:0] CHIME_SEC_0 = 7'd50;
    localparam logic [6:0] CHIME_SEC_1 = 7'd52;
    localparam logic [6:0] CHIME_SEC_2 = 7'd54;
    localparam logic [6:0] CHIME_SEC_3 = 7'd56;
    localparam logic [6:0] CHIME_SEC_4 = 7'd58;

    // Two BCD digits to binary; only meaningful when both digits are <= 9.
    function automatic logic [6:0] bcd2bin(input logic [3:0] tens, input logic [3:0] ones);
        return ({3'b000, tens} * 7'd10) + {3'b000, ones};
    endfunction

    function automatic logic bcd_ok(input logic [3:0] digit);
        return (digit <= 4'd9);
    endfunction

endpackage

// File: rtl/chime_alarm_ctrl_if.sv
// Bundle between the timekeeping counters / buttons and the buzzer sequencer.
interface chime_alarm_ctrl_if;
    logic       tick_1hz;
    logic [3:0] h1, h2, m1, m2, s1, s2;
    logic       chime_en;
    logic       alarm_en;
    logic [3:0] al_h1, al_h2, al_m1, al_m2;
    logic       snooze_btn;
    logic       stop_btn;
    logic [1:0] buzz_mode;
    logic       alarm_ringing;
    logic       alarm_snoozed;

    modport master (
        output tick_1hz, h1, h2, m1, m2, s1, s2, chime_en, alarm_en,
               al_h1, al_h2, al_m1, al_m2, snooze_btn, stop_btn,
        input  buzz_mode, alarm_ringing, alarm_snoozed
    );

    modport slave (
        input  tick_1hz, h1, h2, m1, m2, s1, s2, chime_en, alarm_en,
               al_h1, al_h2, al_m1, al_m2, snooze_btn, stop_btn,
        output buzz_mode, alarm_ringing, alarm_snoozed
    );
endinterface

// File: rtl/chime_alarm_ctrl_sec_countdown.sv
// Loadable seconds down-counter shared by RING and SNOOZE; done pulses on the
// tick that takes the count from 1 to 0.
module sec_countdown #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         tick_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);
    logic [W-1:0] cnt_q;

    // Load has priority over counting; the count saturates at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {W{1'b0}};
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && tick_i && (cnt_q != {W{1'b0}})) begin
            cnt_q <= cnt_q - {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign done_o = en_i && tick_i && (cnt_q == {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/chime_alarm_ctrl.sv
// Buzzer sequencer: hourly chime beeps plus the alarm ring/snooze FSM, with the
// alarm always taking the buzzer over the chime.
module chime_alarm_ctrl
    import chime_pkg::*;
#(
    parameter int SNOOZE_MIN     = 5,
    parameter int RING_TIMEOUT_S = 60,
    parameter int MAX_SNOOZE     = 3
) (
    input  logic              clk,
    input  logic              rst,
    chime_alarm_ctrl_if.slave bus
);
    localparam int SNOOZE_S = SNOOZE_MIN * 60;
    localparam int CNT_MAX  = (SNOOZE_S > RING_TIMEOUT_S) ? SNOOZE_S : RING_TIMEOUT_S;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int SNZ_W    = $clog2(MAX_SNOOZE + 1);

    localparam logic [CNT_W-1:0] RING_LOAD   = CNT_W'(RING_TIMEOUT_S);
    localparam logic [CNT_W-1:0] SNOOZE_LOAD = CNT_W'(SNOOZE_S);
    localparam logic [SNZ_W-1:0] SNZ_LIMIT   = SNZ_W'(MAX_SNOOZE);

    localparam logic [1:0] S_IDLE   = ST_IDLE;
    localparam logic [1:0] S_RING   = ST_RING;
    localparam logic [1:0] S_SNOOZE = ST_SNOOZE;

    logic [1:0]       state_q, state_d;
    logic [SNZ_W-1:0] snz_cnt_q, snz_cnt_d;
    logic [1:0]       beep_mode_q, beep_mode_d;
    logic [1:0]       beep_cnt_q, beep_cnt_d;
    logic [1:0]       buzz_q, buzz_d;
    logic             ringing_q, ringing_d;
    logic             snoozed_q, snoozed_d;

    logic [6:0]       hour_s, min_s, sec_s, al_hour_s, al_min_s;
    logic             time_ok_s, alarm_ok_s;
    logic             chime_short_s, chime_long_s, trigger_s;
    logic             cnt_load_s, cnt_done_s;
    logic [CNT_W-1:0] cnt_load_val_s;

    // Time decode: any non-BCD digit or an hour past 23 blocks every match.
    always_comb begin
        hour_s     = bcd2bin(bus.h1, bus.h2);
        min_s      = bcd2bin(bus.m1, bus.m2);
        sec_s      = bcd2bin(bus.s1, bus.s2);
        al_hour_s  = bcd2bin(bus.al_h1, bus.al_h2);
        al_min_s   = bcd2bin(bus.al_m1, bus.al_m2);
        time_ok_s  = bcd_ok(bus.h1) && bcd_ok(bus.h2) && bcd_ok(bus.m1) &&
                     bcd_ok(bus.m2) && bcd_ok(bus.s1) && bcd_ok(bus.s2) &&
                     (hour_s <= 7'd23);
        alarm_ok_s = bcd_ok(bus.al_h1) && bcd_ok(bus.al_h2) &&
                     bcd_ok(bus.al_m1) && bcd_ok(bus.al_m2) &&
                     (al_hour_s <= 7'd23);
        chime_short_s = bus.tick_1hz && bus.chime_en && time_ok_s &&
                        (min_s == CHIME_MIN) &&
                        ((sec_s == CHIME_SEC_0) || (sec_s == CHIME_SEC_1) ||
                         (sec_s == CHIME_SEC_2) || (sec_s == CHIME_SEC_3) ||
                         (sec_s == CHIME_SEC_4));
        chime_long_s  = bus.tick_1hz && bus.chime_en && time_ok_s &&
                        (min_s == 7'd0) && (sec_s == 7'd0);
        trigger_s     = bus.tick_1hz && bus.alarm_en && time_ok_s && alarm_ok_s &&
                        (state_q == S_IDLE) && (hour_s == al_hour_s) &&
                        (min_s == al_min_s) && (sec_s == 7'd0);
    end

    sec_countdown #(.W(CNT_W)) u_countdown (
        .clk        (clk),
        .rst        (rst),
        .en_i       (state_q != S_IDLE),
        .tick_i     (bus.tick_1hz),
        .load_i     (cnt_load_s),
        .load_val_i (cnt_load_val_s),
        .done_o     (cnt_done_s)
    );

    // Alarm FSM; buttons are evaluated ahead of counter expiry so they win.
    always_comb begin
        state_d        = state_q;
        snz_cnt_d      = snz_cnt_q;
        cnt_load_s     = 1'b0;
        cnt_load_val_s = RING_LOAD;
        case (state_q)
            S_IDLE: begin
                if (trigger_s) begin
                    state_d    = S_RING;
                    cnt_load_s = 1'b1;
                    snz_cnt_d  = {SNZ_W{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RING: begin
                if (!bus.alarm_en || bus.stop_btn) begin
                    state_d = S_IDLE;
                end else if (bus.snooze_btn) begin
                    if (snz_cnt_q < SNZ_LIMIT) begin
                        state_d        = S_SNOOZE;
                        cnt_load_s     = 1'b1;
                        cnt_load_val_s = SNOOZE_LOAD;
                        snz_cnt_d      = snz_cnt_q + {{(SNZ_W-1){1'b0}}, 1'b1};
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (cnt_done_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RING;
                end
            end
            S_SNOOZE: begin
                if (!bus.alarm_en || bus.stop_btn) begin
                    state_d = S_IDLE;
                end else if (cnt_done_s) begin
                    state_d    = S_RING;
                    cnt_load_s = 1'b1;
                end else begin
                    state_d = S_SNOOZE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Chime beep: ringing discards it, the alarm trigger included, so a beep never queues.
    always_comb begin
        beep_mode_d = beep_mode_q;
        beep_cnt_d  = beep_cnt_q;
        if (!bus.chime_en || (state_d == S_RING)) begin
            beep_mode_d = BUZZ_OFF;
            beep_cnt_d  = 2'd0;
        end else if (chime_long_s) begin
            beep_mode_d = BUZZ_LONG;
            beep_cnt_d  = 2'd2;
        end else if (chime_short_s) begin
            beep_mode_d = BUZZ_SHORT;
            beep_cnt_d  = 2'd1;
        end else if (bus.tick_1hz && (beep_cnt_q != 2'd0)) begin
            beep_cnt_d = beep_cnt_q - 2'd1;
            if (beep_cnt_q == 2'd1) begin
                beep_mode_d = BUZZ_OFF;
            end else begin
                beep_mode_d = beep_mode_q;
            end
        end else begin
            beep_cnt_d = beep_cnt_q;
        end
    end

    // Output arbitration from next state so outputs land one edge after the event.
    always_comb begin
        if (state_d == S_RING) begin
            buzz_d = BUZZ_ALARM;
        end else if (beep_cnt_d != 2'd0) begin
            buzz_d = beep_mode_d;
        end else begin
            buzz_d = BUZZ_OFF;
        end
        ringing_d = (state_d == S_RING);
        snoozed_d = (state_d == S_SNOOZE);
    end

    // State, beep and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            snz_cnt_q   <= {SNZ_W{1'b0}};
            beep_mode_q <= BUZZ_OFF;
            beep_cnt_q  <= 2'd0;
            buzz_q      <= BUZZ_OFF;
            ringing_q   <= 1'b0;
            snoozed_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            snz_cnt_q   <= snz_cnt_d;
            beep_mode_q <= beep_mode_d;
            beep_cnt_q  <= beep_cnt_d;
            buzz_q      <= buzz_d;
            ringing_q   <= ringing_d;
            snoozed_q   <= snoozed_d;
        end
    end

    assign bus.buzz_mode     = buzz_q;
    assign bus.alarm_ringing = ringing_q;
    assign bus.alarm_snoozed = snoozed_q;

endmodule

// File: doc/chime_alarm_ctrl.md
# chime_alarm_ctrl

Sequencer that owns the clock's single buzzer and shares it between the hourly chime and the alarm. It watches the BCD time display (HH:MM:SS) on each 1 Hz tick, runs the chime pattern and the alarm ring/snooze state machine, and arbitrates which one drives the buzzer. It sits between the timekeeping counters and the buzzer driver.

## Interface
- SNOOZE_MIN, 5: snooze length in minutes; legal range 1–9.
- RING_TIMEOUT_S, 60: seconds of unattended ringing before the alarm stops itself.
- MAX_SNOOZE, 3: snoozes allowed per alarm event; a further snooze acts as stop.

- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous reset, active-high.
- tick_1hz  in  1  one-cycle pulse, once per second, aligned to the time update.
- h1,h2,m1,m2,s1,s2  in  4 each  BCD time digits; {h1,h2,m1,m2,s1,s2} = HHMMSS. Valid on tick cycles.
- chime_en  in  1  level; enables the hourly chime.
- alarm_en  in  1  level; arms the alarm.
- al_h1,al_h2,al_m1,al_m2  in  4 each  BCD alarm time.
- snooze_btn, stop_btn  in  1 each  one-cycle pulses, already debounced.
- buzz_mode  out  2  00 silent, 01 short chime, 10 long chime, 11 alarm pattern.
- alarm_ringing  out  1  high in RING.
- alarm_snoozed  out  1  high in SNOOZE.

## Operation
- States: IDLE, RING, SNOOZE. The chime is a separate 2-bit beep register, not part of the state machine.
- Time and alarm inputs are sampled only when tick_1hz=1. A digit value above 9, or an hour above 23, never matches anything.
- Chime:
  - When chime_en=1 and MM=59 with SS ∈ {50,52,54,56,58}, load a short beep for 1 s.
  - When chime_en=1 and MM=00 with SS=00, load a long beep for 2 s.
  - A beep ends on the tick that completes its duration.
- Alarm trigger: IDLE→RING when alarm_en=1, HH:MM = alarm time, SS=00. This loads ring_cnt=RING_TIMEOUT_S and sets snooze_cnt=0.
- RING:
  - Each tick decrements ring_cnt; reaching 0 goes to IDLE.
  - stop_btn → IDLE.
  - snooze_btn with snooze_cnt<MAX_SNOOZE → SNOOZE. This loads the countdown with SNOOZE_MIN*60 and increments snooze_cnt.
  - snooze_btn with snooze_cnt=MAX_SNOOZE → IDLE.
- SNOOZE:
  - Each tick decrements the countdown; reaching 0 goes to RING and reloads ring_cnt=RING_TIMEOUT_S.
  - stop_btn → IDLE.
- Leaving IDLE for any reason clears the chime beep register.
- Arbitration, in priority order:
  - RING → buzz_mode=11, and chime beeps are discarded rather than queued.
  - otherwise a chime beep is active → 01 or 10.
  - otherwise → 00.
  - Chimes are allowed during SNOOZE.
- Simultaneous events:
  - stop_btn and snooze_btn in the same cycle: stop wins.
  - Alarm trigger at 00:00:00 together with the long chime: the alarm wins.
  - A button arriving in the same cycle as the tick that expires a counter: the button wins.
- alarm_en falling in RING or SNOOZE forces IDLE on the next clock edge.
- chime_en falling cancels an active beep on the next edge.
- Changing the alarm time while in SNOOZE has no effect on the current event.

## Timing
- All outputs are registered. A tick or button in cycle N is reflected on the outputs in cycle N+1.
- A short beep is exactly one tick period; a long beep is exactly two.
- Reset values: state IDLE, buzz_mode=00, alarm_ringing=0, alarm_snoozed=0, all counters 0. Reset mid-ring or mid-snooze silences the buzzer on the next edge.
- Counter width is clog2(max(SNOOZE_MIN*60, RING_TIMEOUT_S)+1); decrements saturate at 0.
- A retrigger match while in RING or SNOOZE is ignored. IDLE→RING is possible again only at the next matching SS=00.

## Structure
- Shared package chime_pkg holds:
  - the state enum;
  - the buzz_mode codes BUZZ_OFF, BUZZ_SHORT, BUZZ_LONG, BUZZ_ALARM;
  - the chime second constants 50/52/54/56/58;
  - the bcd2bin function.
- One sub-module, sec_countdown: a loadable down-counter enabled by tick_1hz, with a done pulse. It is instantiated once and shared by RING and SNOOZE, since they are mutually exclusive.

## Test plan
- chime_en=1, tick through 00:59:49–01:00:03 → buzz_mode=01 for one tick at each of 50/52/54/56/58; buzz_mode=10 for ticks 00 and 01; 00 elsewhere.
- Alarm 07:30, alarm_en=1, reach 07:30:00 → alarm_ringing=1 and buzz_mode=11 the cycle after the tick; with no buttons, IDLE after 60 ticks.
- RING, snooze_btn → alarm_snoozed=1 and silence; after 300 ticks → RING again. Snooze 3 times, then a 4th snooze → IDLE.
- Alarm 00:00 with chime_en=1 at 23:59:59→00:00:00 → buzz_mode=11, no 10. Chime at x:59:50 during RING is suppressed.
- stop_btn and snooze_btn pulsed in the same cycle in RING → IDLE. alarm_en dropped in SNOOZE → IDLE next cycle.
- rst asserted mid-RING → all outputs 0 next edge. Time digits m2=4'hA with alarm otherwise matching → no trigger.
